neuron_scheduler: RTL

//  Time-multiplexes one leaky integrate-and-fire datapath across NUM_NEURONS virtual neurons.
//  On each timestep it sweeps the neurons in order: it fetches each neuron's synaptic sum

---
 rtl/snn_pkg.sv | 29 ++
 rtl/lif_update_unit.sv | 26 ++
 rtl/neuron_scheduler.sv | 138 +++++++++++++
 3 files changed

// File: rtl/snn_pkg.sv
// Shared defaults, scheduler state encoding and saturating add for the LIF neuron scheduler.
package snn_pkg;

   localparam int unsigned DEF_NUM_NEURONS = 8;
   localparam int unsigned DEF_WIDTH       = 8;
   localparam int          DEF_THRESHOLD   = 25;
   localparam int unsigned DEF_LEAK_SHIFT  = 1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      REQ    = 2'd1,
      UPDATE = 2'd2,
      DONE   = 2'd3
   } sched_state_t;

   // Adds two sign-extended operands and clamps the result to a w-bit signed range.
   function automatic int sat_add(input int a, input int b, input int unsigned w);
      int sum;
      int hi;
      int lo;
      sum = a + b;
      hi  = (1 << (w - 32'd1)) - 1;
      lo  = -hi - 1;
      if (sum > hi) return hi;
      if (sum < lo) return lo;
      return sum;
   endfunction

endpackage

// File: rtl/lif_update_unit.sv
// Combinational leaky integrate-and-fire step: leak, saturating integrate, threshold, reset-by-subtraction.
module lif_update_unit
   import snn_pkg::*;
#(
   parameter int unsigned WIDTH      = DEF_WIDTH,
   parameter int          THRESHOLD  = DEF_THRESHOLD,
   parameter int unsigned LEAK_SHIFT = DEF_LEAK_SHIFT
) (
   input  logic signed [WIDTH-1:0] v_old,
   input  logic signed [WIDTH-1:0] mac_data,
   output logic signed [WIDTH-1:0] v_new,
   output logic                    spike
);

   logic signed [WIDTH-1:0] leaked;
   logic signed [WIDTH-1:0] summed;

   always_comb begin
      leaked = v_old >>> LEAK_SHIFT;
      summed = WIDTH'(sat_add(int'(leaked), int'(mac_data), WIDTH));
      spike  = (int'(summed) >= THRESHOLD);
      // summed >= THRESHOLD here, so the subtraction cannot underflow
      v_new  = spike ? WIDTH'(int'(summed) - THRESHOLD) : summed;
   end

endmodule

// File: rtl/neuron_scheduler.sv
// Sweeps NUM_NEURONS virtual LIF neurons per timestep through one shared update unit,
// fetching each synaptic sum from the MAC stage over a req/valid handshake.
module neuron_scheduler
   import snn_pkg::*;
#(
   parameter int unsigned NUM_NEURONS = DEF_NUM_NEURONS,
   parameter int unsigned WIDTH       = DEF_WIDTH,
   parameter int          THRESHOLD   = DEF_THRESHOLD,
   parameter int unsigned LEAK_SHIFT  = DEF_LEAK_SHIFT
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           step,
   output logic                           mac_req,
   output logic [$clog2(NUM_NEURONS)-1:0] mac_idx,
   input  logic                           mac_valid,
   input  logic signed [WIDTH-1:0]        mac_data,
   output logic [NUM_NEURONS-1:0]         spk_vec,
   output logic                           spk_valid,
   output logic                           busy,
   output logic                           step_overrun
);

   localparam int unsigned IDX_W = $clog2(NUM_NEURONS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NEURONS - 1);

   sched_state_t            state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic signed [WIDTH-1:0] mac_data_q, mac_data_d;
   logic signed [WIDTH-1:0] mem_q [NUM_NEURONS];
   logic signed [WIDTH-1:0] mem_d [NUM_NEURONS];
   logic [NUM_NEURONS-1:0]  pend_q, pend_d;
   logic [NUM_NEURONS-1:0]  spk_vec_q, spk_vec_d;
   logic                    mac_req_q, mac_req_d;
   logic                    spk_valid_q, spk_valid_d;
   logic                    busy_q, busy_d;
   logic                    overrun_q, overrun_d;

   logic signed [WIDTH-1:0] v_new;
   logic                    spike;

   lif_update_unit #(
      .WIDTH      (WIDTH),
      .THRESHOLD  (THRESHOLD),
      .LEAK_SHIFT (LEAK_SHIFT)
   ) u_lif (
      .v_old    (mem_q[idx_q]),
      .mac_data (mac_data_q),
      .v_new    (v_new),
      .spike    (spike)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         idx_q       <= '0;
         mac_data_q  <= '0;
         pend_q      <= '0;
         spk_vec_q   <= '0;
         mac_req_q   <= 1'b0;
         spk_valid_q <= 1'b0;
         busy_q      <= 1'b0;
         overrun_q   <= 1'b0;
         for (int unsigned i = 0; i < NUM_NEURONS; i++) mem_q[i] <= '0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         mac_data_q  <= mac_data_d;
         pend_q      <= pend_d;
         spk_vec_q   <= spk_vec_d;
         mac_req_q   <= mac_req_d;
         spk_valid_q <= spk_valid_d;
         busy_q      <= busy_d;
         overrun_q   <= overrun_d;
         for (int unsigned i = 0; i < NUM_NEURONS; i++) mem_q[i] <= mem_d[i];
      end
   end

   // Next-state logic; output registers are loaded from the state being entered.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      mac_data_d  = mac_data_q;
      pend_d      = pend_q;
      spk_vec_d   = spk_vec_q;
      spk_valid_d = 1'b0;
      mem_d       = mem_q;
      overrun_d   = step & busy_q;

      case (state_q)
         IDLE: begin
            if (step) begin
               state_d = REQ;
               idx_d   = '0;
               pend_d  = '0;
            end
         end
         REQ: begin
            if (mac_valid) begin
               mac_data_d = mac_data;
               state_d    = UPDATE;
            end
         end
         UPDATE: begin
            mem_d[idx_q]  = v_new;
            pend_d[idx_q] = spike;
            if (idx_q == LAST_IDX) begin
               state_d     = DONE;
               spk_vec_d   = pend_d;
               spk_valid_d = 1'b1;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = REQ;
            end
         end
         DONE: begin
            state_d = IDLE;
            if (step) begin
               state_d = REQ;
               idx_d   = '0;
               pend_d  = '0;
            end
         end
         default: state_d = IDLE;
      endcase

      mac_req_d = (state_d == REQ);
      busy_d    = (state_d == REQ) || (state_d == UPDATE);
   end

   assign mac_req      = mac_req_q;
   assign mac_idx      = idx_q;
   assign spk_vec      = spk_vec_q;
   assign spk_valid    = spk_valid_q;
   assign busy         = busy_q;
   assign step_overrun = overrun_q;

endmodule
